// File: rtl/preempt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : preempt_pkg
//  Description : Shared types for the preemption context-switch handler.
//                Holds the FSM state encoding, the saved-context record and
//                the round-robin successor function.
//  Revision    : 1.0 - initial release
// ============================================================================
package preempt_pkg;

    // The context record carries these widths. The handler's ADDR_W/DATA_W
    // default to the same values and must stay equal to them.
    localparam int c_ctx_addr_w = 10;
    localparam int c_ctx_data_w = 16;

    typedef enum logic [2:0] {
        ST_BOOT     = 3'd0,
        ST_IDLE     = 3'd1,
        ST_WAIT_BND = 3'd2,
        ST_SAVE     = 3'd3,
        ST_LOAD     = 3'd4,
        ST_RESUME   = 3'd5
    } state_t;

    typedef struct packed {
        logic [c_ctx_addr_w-1:0] pc;
        logic [c_ctx_data_w-1:0] acc;
    } ctx_t;

    // Round-robin successor: wraps from the last process back to 0.
    // With a single process the successor is always 0.
    function automatic int unsigned next_proc(input int unsigned idx,
                                              input int unsigned num_proc);
        return (idx + 1 >= num_proc) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctx_table.sv
`default_nettype none
// ============================================================================
//  Module      : ctx_table
//  Description : NUM_PROC-entry flop-based register file of saved contexts.
//                One synchronous write port, one asynchronous read port.
//                Reset loads each entry with its base PC
//                (index in the top PROC_W bits of the PC) and ACC = 0.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                i_we/i_waddr/i_wdata - write port
//                i_raddr/o_rdata     - combinational read port
//  Revision    : 1.0 - initial release
// ============================================================================
module ctx_table
    import preempt_pkg::*;
#(
    parameter int NUM_PROC = 4,
    parameter int PROC_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [PROC_W-1:0] i_waddr,
    input  ctx_t              i_wdata,
    input  logic [PROC_W-1:0] i_raddr,
    output ctx_t              o_rdata
);

    ctx_t r_mem [NUM_PROC];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PROC; i++) begin
                r_mem[i].acc                              <= '0;
                r_mem[i].pc                               <= '0;
                r_mem[i].pc[c_ctx_addr_w-1 -: PROC_W]     <= PROC_W'(i);
            end
        end else begin
            for (int i = 0; i < NUM_PROC; i++) begin
                if (i_we && (i_waddr == PROC_W'(i))) begin
                    r_mem[i] <= i_wdata;
                end
            end
        end
    end

    always_comb begin
        o_rdata = r_mem[0];
        for (int i = 1; i < NUM_PROC; i++) begin
            if (i_raddr == PROC_W'(i)) begin
                o_rdata = r_mem[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/preempt_handler.sv
`default_nettype none
// ============================================================================
//  Module      : preempt_handler
//  Description : Round-robin context switcher driven by the preemption
//                timer. Waits for an instruction boundary, saves PC/ACC of
//                the running process, reloads the next process, flushes IR
//                and re-arms the timer.
//  Ports       : clk, rst_n       - clock, async active-low reset
//                i_enable         - scheduler enable
//                i_preempt        - timer pulse
//                i_instr_done     - instruction retires this cycle
//                i_pc_in/i_acc_in - running process state
//                o_halt_cpu, o_ir_flush, o_ctx_load, o_start_count - control
//                o_pc_out/o_acc_out - incoming process state (registered)
//                o_cur_proc       - running process index
//                o_switch_busy    - FSM not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module preempt_handler
    import preempt_pkg::*;
#(
    parameter int DATA_W   = c_ctx_data_w,
    parameter int ADDR_W   = c_ctx_addr_w,
    parameter int NUM_PROC = 4,
    parameter int PROC_W   = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_enable,
    input  logic              i_preempt,
    input  logic              i_instr_done,
    input  logic [ADDR_W-1:0] i_pc_in,
    input  logic [DATA_W-1:0] i_acc_in,
    output logic              o_halt_cpu,
    output logic              o_ir_flush,
    output logic              o_ctx_load,
    output logic [ADDR_W-1:0] o_pc_out,
    output logic [DATA_W-1:0] o_acc_out,
    output logic              o_start_count,
    output logic [PROC_W-1:0] o_cur_proc,
    output logic              o_switch_busy
);

    state_t            r_state, w_state_nxt;
    logic              r_pending, w_pending_nxt;
    logic              r_boot_go;
    logic [PROC_W-1:0] r_cur_proc, w_nxt_proc;
    logic [ADDR_W-1:0] r_save_pc, r_pc_out;
    logic [DATA_W-1:0] r_save_acc, r_acc_out;
    ctx_t              w_save_ctx, w_rd_ctx, w_load_ctx;

    assign w_nxt_proc = PROC_W'(next_proc(32'(r_cur_proc), NUM_PROC));
    assign w_save_ctx = '{pc: r_save_pc, acc: r_save_acc};

    // The table write of SAVE lands on the same edge that captures the
    // reload, so a self-switch (single process) must take the save regs.
    assign w_load_ctx = (w_nxt_proc == r_cur_proc) ? w_save_ctx : w_rd_ctx;

    ctx_table #(
        .NUM_PROC (NUM_PROC),
        .PROC_W   (PROC_W)
    ) u_ctx_table (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (r_state == ST_SAVE),
        .i_waddr (r_cur_proc),
        .i_wdata (w_save_ctx),
        .i_raddr (w_nxt_proc),
        .o_rdata (w_rd_ctx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_BOOT;
            r_pending  <= 1'b0;
            r_boot_go  <= 1'b0;
            r_cur_proc <= '0;
            r_save_pc  <= '0;
            r_save_acc <= '0;
            r_pc_out   <= '0;
            r_acc_out  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            // Goes high on the first edge after release; keeps the BOOT
            // timer-arm pulse out of the reset period itself.
            r_boot_go <= 1'b1;
            if ((r_state == ST_WAIT_BND) && i_instr_done) begin
                r_save_pc  <= i_pc_in;
                r_save_acc <= i_acc_in;
            end
            if (r_state == ST_SAVE) begin
                r_pc_out  <= w_load_ctx.pc;
                r_acc_out <= w_load_ctx.acc;
            end
            if (r_state == ST_LOAD) begin
                r_cur_proc <= w_nxt_proc;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        o_halt_cpu    = 1'b0;
        o_ir_flush    = 1'b0;
        o_ctx_load    = 1'b0;
        o_start_count = 1'b0;
        case (r_state)
            ST_BOOT: begin
                o_start_count = r_boot_go;
                if (r_boot_go) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (i_preempt && i_enable) begin
                    w_state_nxt = ST_WAIT_BND;
                end
            end
            ST_WAIT_BND: begin
                if (i_preempt) begin
                    w_pending_nxt = 1'b1;
                end
                if (i_instr_done) begin
                    w_state_nxt = ST_SAVE;
                end
            end
            ST_SAVE: begin
                o_halt_cpu = 1'b1;
                o_ir_flush = 1'b1;
                if (i_preempt) begin
                    w_pending_nxt = 1'b1;
                end
                w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                o_halt_cpu = 1'b1;
                o_ctx_load = 1'b1;
                if (i_preempt) begin
                    w_pending_nxt = 1'b1;
                end
                w_state_nxt = ST_RESUME;
            end
            ST_RESUME: begin
                o_start_count = 1'b1;
                w_pending_nxt = 1'b0;
                // A pulse arriving in RESUME is folded into the pending
                // decision so it is never left stranded in the flag.
                if ((r_pending || i_preempt) && i_enable) begin
                    w_state_nxt = ST_WAIT_BND;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

    assign o_switch_busy = (r_state != ST_IDLE);
    assign o_pc_out      = r_pc_out;
    assign o_acc_out     = r_acc_out;
    assign o_cur_proc    = r_cur_proc;

endmodule
`default_nettype wire
